// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall/flush decisions for a five-stage pipeline
// with a multi-cycle vector unit in EX and a MEM stage that can wait on memory.
module pipe_ctrl #(
    parameter int unsigned VLAT = 4,   // vector-unit EX occupancy, 2..255
    parameter int unsigned RW   = 5    // register-address width
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          ex_memread,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_branch_taken,
    input  logic          vec_start,
    input  logic          mem_req,
    input  logic          mem_ready,
    output logic          pc_hold,
    output logic          hold_if_id,
    output logic          hold_id_ex,
    output logic          hold_ex_mem,
    output logic          hold_mem_wb,
    output logic          clear_if_id,
    output logic          clear_id_ex,
    output logic          clear_ex_mem,
    output logic          clear_mem_wb,
    output logic          vec_busy,
    output logic [15:0]   stall_count
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        VEC  = 2'd1,
        MEMW = 2'd2
    } state_t;

    // The RUN cycle that sees vec_start and the final cnt=0 cycle both count
    // towards the occupancy, hence the load value of VLAT-2.
    localparam logic [7:0] CNT_INIT = 8'(VLAT - 2);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    logic [15:0] r_stall_count;
    logic        w_memwait;
    logic        w_loaduse;

    assign w_memwait = mem_req & ~mem_ready;
    assign w_loaduse = ex_memread & (ex_rd != '0) & ((ex_rd == id_rs) | (ex_rd == id_rt));

    // Next-state and Mealy hold/clear decode; reset overrides to "clear all".
    always_comb begin
        // NOTE: every output gets a default before the case so no path can leave
        // a signal unassigned and infer a latch.
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        pc_hold      = 1'b0;
        hold_if_id   = 1'b0;
        hold_id_ex   = 1'b0;
        hold_ex_mem  = 1'b0;
        hold_mem_wb  = 1'b0;
        clear_if_id  = 1'b0;
        clear_id_ex  = 1'b0;
        clear_ex_mem = 1'b0;
        clear_mem_wb = 1'b0;

        case (r_state)
            VEC: begin
                if (w_memwait) begin
                    // Memory stall freezes everything up to EX/MEM; the vector
                    // unit keeps working underneath it.
                    pc_hold      = 1'b1;
                    hold_if_id   = 1'b1;
                    hold_id_ex   = 1'b1;
                    hold_ex_mem  = 1'b1;
                    clear_mem_wb = 1'b1;
                    if (r_cnt != 8'd0) w_cnt_nxt = r_cnt - 8'd1;
                end else if (r_cnt != 8'd0) begin
                    pc_hold      = 1'b1;
                    hold_if_id   = 1'b1;
                    hold_id_ex   = 1'b1;
                    clear_ex_mem = 1'b1;
                    w_cnt_nxt    = r_cnt - 8'd1;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                // RUN, and MEMW once memory is no longer waiting, decode alike.
                w_state_nxt = RUN;
                if (w_memwait) begin
                    pc_hold      = 1'b1;
                    hold_if_id   = 1'b1;
                    hold_id_ex   = 1'b1;
                    hold_ex_mem  = 1'b1;
                    clear_mem_wb = 1'b1;
                    w_state_nxt  = MEMW;
                end else if (vec_start) begin
                    pc_hold      = 1'b1;
                    hold_if_id   = 1'b1;
                    hold_id_ex   = 1'b1;
                    clear_ex_mem = 1'b1;
                    w_cnt_nxt    = CNT_INIT;
                    w_state_nxt  = VEC;
                end else if (ex_branch_taken) begin
                    // The flush squashes the consumer, so load-use is moot.
                    clear_if_id = 1'b1;
                    clear_id_ex = 1'b1;
                end else if (w_loaduse) begin
                    pc_hold     = 1'b1;
                    hold_if_id  = 1'b1;
                    clear_id_ex = 1'b1;
                end
            end
        endcase

        if (!rst_n) begin
            pc_hold      = 1'b0;
            hold_if_id   = 1'b0;
            hold_id_ex   = 1'b0;
            hold_ex_mem  = 1'b0;
            hold_mem_wb  = 1'b0;
            clear_if_id  = 1'b1;
            clear_id_ex  = 1'b1;
            clear_ex_mem = 1'b1;
            clear_mem_wb = 1'b1;
        end
    end

    // State, vector countdown and saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_cnt         <= 8'd0;
            r_stall_count <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples
            // pre-edge values, independent of statement order.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (pc_hold && (r_stall_count != 16'hFFFF))
                r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign vec_busy    = (r_state == VEC);
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: decode table, directed multi-cycle
// sequences, long stall saturation and a randomized run against a model.
module tb_pipe_ctrl;

    localparam int VLAT = 4;
    localparam int RW   = 5;

    // Output vector order: {pc_hold, hold_if_id, hold_id_ex, hold_ex_mem,
    // hold_mem_wb, clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb, vec_busy}
    localparam logic [9:0] NONE   = 10'b0000000000;
    localparam logic [9:0] MEMST  = 10'b1111000010;
    localparam logic [9:0] VECST  = 10'b1110000100;
    localparam logic [9:0] FLUSH  = 10'b0000011000;
    localparam logic [9:0] BUBBLE = 10'b1100001000;
    localparam logic [9:0] RSTV   = 10'b0000011110;
    localparam logic [9:0] VB     = 10'b0000000001;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [RW-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic          ex_memread = 1'b0, ex_branch_taken = 1'b0, vec_start = 1'b0;
    logic          mem_req = 1'b0, mem_ready = 1'b0;
    logic          pc_hold, hold_if_id, hold_id_ex, hold_ex_mem, hold_mem_wb;
    logic          clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb, vec_busy;
    logic [15:0]   stall_count;
    logic [9:0]    outs;

    int total = 0;
    int bad   = 0;

    pipe_ctrl #(.VLAT(VLAT), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .ex_memread(ex_memread), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .vec_start(vec_start),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_hold(pc_hold), .hold_if_id(hold_if_id), .hold_id_ex(hold_id_ex),
        .hold_ex_mem(hold_ex_mem), .hold_mem_wb(hold_mem_wb),
        .clear_if_id(clear_if_id), .clear_id_ex(clear_id_ex),
        .clear_ex_mem(clear_ex_mem), .clear_mem_wb(clear_mem_wb),
        .vec_busy(vec_busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    assign outs = {pc_hold, hold_if_id, hold_id_ex, hold_ex_mem, hold_mem_wb,
                   clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb, vec_busy};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                          input logic [RW-1:0] rd, input logic mr, input logic br,
                          input logic vs, input logic mq, input logic my);
        id_rs = rs; id_rt = rt; ex_rd = rd; ex_memread = mr;
        ex_branch_taken = br; vec_start = vs; mem_req = mq; mem_ready = my;
    endtask

    // Apply inputs, check the combinational outputs, then move past one edge.
    task automatic step(input string name, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                        input logic [RW-1:0] rd, input logic mr, input logic br,
                        input logic vs, input logic mq, input logic my, input logic [9:0] e);
        set_in(rs, rt, rd, mr, br, vs, mq, my);
        #1;
        check(name, 32'(outs), 32'(e));
        @(negedge clk);
    endtask

    // Short asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        @(negedge clk);
        set_in('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- reference model ----------------
    // Tracks only whether a vector op is occupying EX and how many more
    // stalled cycles it needs; a memory wait outside a vector op has no memory
    // beyond the current inputs.
    bit m_vec;
    int m_left;
    int m_stall;

    function automatic logic [9:0] model_out(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                                             input logic [RW-1:0] rd, input logic mr,
                                             input logic br, input logic vs,
                                             input logic mq, input logic my);
        bit mw = mq && !my;
        bit lu = mr && (rd != 0) && ((rd == rs) || (rd == rt));
        if (m_vec) begin
            if (mw)         return MEMST | VB;
            if (m_left > 0) return VECST | VB;
            return VB;
        end
        if (mw) return MEMST;
        if (vs) return VECST;
        if (br) return FLUSH;
        if (lu) return BUBBLE;
        return NONE;
    endfunction

    task automatic model_advance(input logic [9:0] e, input logic vs, input logic mq, input logic my);
        bit mw = mq && !my;
        if (e[9]) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        if (m_vec) begin
            if (mw)              m_left = (m_left > 0) ? m_left - 1 : 0;
            else if (m_left > 0) m_left = m_left - 1;
            else                 m_vec  = 1'b0;
        end else if (!mw && vs) begin
            m_vec  = 1'b1;
            m_left = VLAT - 2;
        end
    endtask

    typedef struct {
        logic [RW-1:0] rs, rt, rd;
        logic          mr, br, vs, mq, my;
        logic [9:0]    exp;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int n_hold, n_vb_hold;
        logic [9:0] e;

        tbl[0]  = '{rs:0, rt:0, rd:0, mr:0, br:0, vs:0, mq:0, my:0, exp:NONE};
        tbl[1]  = '{rs:3, rt:9, rd:3, mr:1, br:0, vs:0, mq:0, my:0, exp:BUBBLE};
        tbl[2]  = '{rs:1, rt:7, rd:7, mr:1, br:0, vs:0, mq:0, my:0, exp:BUBBLE};
        tbl[3]  = '{rs:0, rt:0, rd:0, mr:1, br:0, vs:0, mq:0, my:0, exp:NONE};
        tbl[4]  = '{rs:4, rt:5, rd:3, mr:1, br:0, vs:0, mq:0, my:0, exp:NONE};
        tbl[5]  = '{rs:3, rt:3, rd:3, mr:0, br:0, vs:0, mq:0, my:0, exp:NONE};
        tbl[6]  = '{rs:3, rt:0, rd:3, mr:1, br:1, vs:0, mq:0, my:0, exp:FLUSH};
        tbl[7]  = '{rs:3, rt:0, rd:3, mr:1, br:1, vs:1, mq:0, my:0, exp:VECST};
        tbl[8]  = '{rs:3, rt:0, rd:3, mr:1, br:1, vs:1, mq:1, my:0, exp:MEMST};
        tbl[9]  = '{rs:2, rt:0, rd:2, mr:1, br:0, vs:0, mq:1, my:1, exp:BUBBLE};
        tbl[10] = '{rs:0, rt:0, rd:0, mr:0, br:0, vs:0, mq:1, my:1, exp:NONE};

        // Reset state, asserted with busy-looking inputs and no clock edge yet.
        set_in(5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs", 32'(outs), 32'(RSTV));
        check("reset_stall_count", 32'(stall_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("reset_held_outputs", 32'(outs), 32'(RSTV));
        rst_n = 1'b1;

        // Decode table, each entry evaluated in RUN right after reset.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            set_in(tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].mr, tbl[i].br,
                   tbl[i].vs, tbl[i].mq, tbl[i].my);
            #1;
            check($sformatf("table[%0d]", i), 32'(outs), 32'(tbl[i].exp));
        end

        // Load-use bubble lasts exactly one cycle as the load moves on.
        do_reset();
        step("lu_bubble", 5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BUBBLE);
        step("lu_after",  5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        check("lu_stall_count", 32'(stall_count), 32'd1);

        // Vector op, vec_start held for its full occupancy.
        do_reset();
        n_hold = 0;
        n_vb_hold = 0;
        for (int i = 0; i < 4; i++) begin
            e = (i == 0) ? VECST : (i < 3) ? (VECST | VB) : VB;
            set_in('0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            #1;
            check($sformatf("vec_cycle%0d", i), 32'(outs), 32'(e));
            if (pc_hold) n_hold++;
            if (pc_hold && vec_busy) n_vb_hold++;
            @(negedge clk);
        end
        check("vec_pc_hold_cycles", 32'(n_hold), 32'd3);
        check("vec_busy_stalled_cycles", 32'(n_vb_hold), 32'd2);
        step("vec_done", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        check("vec_stall_count", 32'(stall_count), 32'd3);

        // Memory wait while the vector op is at cnt=1: loaduse/branch ignored.
        do_reset();
        step("vm_c0", '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, VECST);
        step("vm_c1", '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, VECST | VB);
        step("vm_w0", 5'd2, '0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, MEMST | VB);
        step("vm_w1", 5'd2, '0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, MEMST | VB);
        step("vm_w2", 5'd2, '0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, MEMST | VB);
        step("vm_rel", 5'd2, '0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, VB);
        step("vm_run", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        check("vm_stall_count", 32'(stall_count), 32'd5);

        // MEMW exits into RUN-style decode when memory completes.
        do_reset();
        step("mw_wait", 5'd1, '0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, MEMST);
        step("mw_wait2", 5'd1, '0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, MEMST);
        step("mw_ready_vec", '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, VECST);
        step("mw_in_vec", '0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, VECST | VB);

        // Reset asserted mid-MEMW.
        do_reset();
        step("rm_w0", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, MEMST);
        step("rm_w1", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, MEMST);
        check("rm_count_before", 32'(stall_count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("rm_async_outputs", 32'(outs), 32'(RSTV));
        check("rm_async_count", 32'(stall_count), 32'd0);
        @(negedge clk);
        check("rm_held_outputs", 32'(outs), 32'(RSTV));
        rst_n = 1'b1;
        step("rm_release", '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        step("rm_first_run", 5'd6, '0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BUBBLE);

        // Long memory stall: counter saturates without wrapping.
        do_reset();
        set_in('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 70000; i++) begin
            @(negedge clk);
            if (i == 65534) check("sat_fffe", 32'(stall_count), 32'h0000FFFE);
            if (i == 65535) check("sat_ffff", 32'(stall_count), 32'h0000FFFF);
        end
        check("sat_hold", 32'(stall_count), 32'h0000FFFF);
        check("sat_outputs", 32'(outs), 32'(MEMST));

        // Randomized run against the reference model.
        do_reset();
        m_vec = 1'b0;
        m_left = 0;
        m_stall = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [RW-1:0] rs, rt, rd;
            logic mr, br, vs, mq, my;
            rs = RW'($urandom_range(0, 3));
            rt = RW'($urandom_range(0, 3));
            rd = RW'($urandom_range(0, 3));
            mr = ($urandom_range(0, 1) == 1);
            br = ($urandom_range(0, 3) == 0);
            vs = ($urandom_range(0, 9) == 0);
            mq = ($urandom_range(0, 2) == 0);
            my = ($urandom_range(0, 1) == 1);
            set_in(rs, rt, rd, mr, br, vs, mq, my);
            #1;
            e = model_out(rs, rt, rd, mr, br, vs, mq, my);
            check($sformatf("rand%0d_outs", i), 32'(outs), 32'(e));
            check($sformatf("rand%0d_count", i), 32'(stall_count), 32'(m_stall));
            model_advance(e, vs, mq, my);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
